// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and helpers for the SPI receive slice. It holds
//               the SPI mode encoding, the sampling-edge helper and the
//               receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  // CPOL is bit 1 and CPHA is bit 0.
  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } rx_state_t;

  // Modes 1 and 2 sample on the falling edge of sclk.
  // Modes 0 and 3 sample on the rising edge.
  function automatic logic sample_on_falling(input spi_mode_t mode);
    return mode[0] ^ mode[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_fifo
// Description : Synchronous FIFO for received words. The head entry is read
//               straight from storage, so the output stays stable until it is
//               popped. A push while full is dropped and reported unless a pop
//               in the same cycle frees the slot.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               i_push       - write request, i_push_data is the entry
//               i_pop        - read request (ignored when empty)
//               o_rd_data    - head entry
//               o_valid      - FIFO non-empty
//               o_level      - occupied entries
//               o_overrun    - one-cycle pulse, push dropped while full
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overrun;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push_ok;

  assign w_full  = (r_level == LW'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = i_pop && !w_empty;
  // A pop in the same cycle frees the slot, so a push to a full FIFO is still accepted.
  assign w_push_ok = i_push && (!w_full || w_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push_ok && !w_pop)      r_level <= r_level + LW'(1);
      else if (!w_push_ok && w_pop) r_level <= r_level - LW'(1);
      r_overrun <= i_push && !w_push_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_valid   = !w_empty;
  assign o_level   = r_level;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx
// Description : SPI receive slice with chip-select framing, runtime word
//               length and bit order, and input synchronisers. Received words
//               feed an AXI-Stream output FIFO that tags the first word of
//               each frame.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               sclk, rxd, cs_n - asynchronous SPI pins
//               spi_mode, word_len, lsb_first
//                               - frame configuration, latched when cs_n falls
//               m_axis_*        - received words, where tuser marks the first
//                                 word of a frame
//               busy            - frame in progress
//               fifo_level      - occupied FIFO entries
//               overrun_error   - pulse when a word is dropped because the
//                                 FIFO is full
//               frame_error     - pulse when cs_n rises with a partial word
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [DATA_WIDTH-1:0]             m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tuser,
  input  logic                              sclk,
  input  logic                              rxd,
  input  logic                              cs_n,
  input  logic [1:0]                        spi_mode,
  input  logic [$clog2(DATA_WIDTH+1)-1:0]   word_len,
  input  logic                              lsb_first,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              overrun_error,
  output logic                              frame_error
);

  localparam int LEN_W = $clog2(DATA_WIDTH+1);

  // Synchronisers. cs_n resets low, so a frame already in progress at reset
  // is never mistaken for an idle bus.
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_rxd_sync, r_cs_sync;
  logic                   r_sclk_prev, r_cs_prev;
  logic                   w_sclk, w_rxd, w_cs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_rxd_sync  <= '0;
      r_cs_sync   <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_rxd_sync  <= {r_rxd_sync[SYNC_STAGES-2:0], rxd};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sclk_prev <= w_sclk;
      r_cs_prev   <= w_cs;
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_rxd  = r_rxd_sync[SYNC_STAGES-1];
  assign w_cs   = r_cs_sync[SYNC_STAGES-1];

  // Frame configuration, latched on the cs_n falling edge.
  logic             r_falling;
  logic [LEN_W-1:0] r_len;
  logic             r_lsb;

  logic             w_cs_fall, w_cs_rise, w_sample_edge;
  logic [LEN_W-1:0] w_len_clamped;

  assign w_cs_fall     = r_cs_prev & ~w_cs;
  assign w_cs_rise     = ~r_cs_prev & w_cs;
  assign w_sample_edge = r_falling ? (r_sclk_prev & ~w_sclk) : (~r_sclk_prev & w_sclk);
  assign w_len_clamped = (word_len == '0 || word_len > LEN_W'(DATA_WIDTH))
                         ? LEN_W'(DATA_WIDTH) : word_len;

  // FSM
  rx_state_t r_state, w_state_nxt;
  logic      w_start, w_shift_en, w_end;

  always_ff @(posedge clk) begin
    if (rst) r_state <= WAIT_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_end       = 1'b0;
    case (r_state)
      WAIT_IDLE: if (w_cs) w_state_nxt = IDLE;
      IDLE: begin
        if (w_cs_fall) begin
          w_start     = 1'b1;
          w_state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        w_shift_en = w_sample_edge;
        if (w_cs_rise) begin
          w_end       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = WAIT_IDLE;
    endcase
  end

  // Shift datapath
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic [LEN_W-1:0]      r_bit_cnt, w_bit_cnt_inc;
  logic                  r_first;
  logic                  r_push;
  logic [DATA_WIDTH:0]   r_push_data;
  logic                  r_frame_err;
  logic                  w_word_done;

  assign w_bit_cnt_inc = r_bit_cnt + LEN_W'(1);
  assign w_word_done   = w_shift_en && (w_bit_cnt_inc == r_len);
  // The shift register is cleared for every word, so OR-ing in a bit is the
  // same as writing it.
  assign w_shift_nxt   = r_lsb ? (r_shift | (DATA_WIDTH'(w_rxd) << r_bit_cnt))
                               : {r_shift[DATA_WIDTH-2:0], w_rxd};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_falling   <= 1'b0;
      r_len       <= '0;
      r_lsb       <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_first     <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_start) begin
        r_falling <= sample_on_falling(spi_mode_t'(spi_mode));
        r_len     <= w_len_clamped;
        r_lsb     <= lsb_first;
        r_first   <= 1'b1;
        r_shift   <= '0;
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        if (w_word_done) begin
          r_push      <= 1'b1;
          r_push_data <= {r_first, w_shift_nxt};
          r_shift     <= '0;
          r_bit_cnt   <= '0;
          r_first     <= 1'b0;
        end else begin
          r_shift   <= w_shift_nxt;
          r_bit_cnt <= w_bit_cnt_inc;
        end
      end
      // A sampling edge in the same cycle is applied before this point. A
      // word completed in that cycle is kept, and only a partial word is
      // reported as a frame error.
      if (w_end) begin
        r_frame_err <= w_shift_en ? !w_word_done : (r_bit_cnt != '0);
        r_shift     <= '0;
        r_bit_cnt   <= '0;
      end
    end
  end

  logic [DATA_WIDTH:0] w_fifo_out;

  spi_rx_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_push),
    .i_push_data (r_push_data),
    .i_pop       (m_axis_tready),
    .o_rd_data   (w_fifo_out),
    .o_valid     (m_axis_tvalid),
    .o_level     (fifo_level),
    .o_overrun   (overrun_error)
  );

  assign m_axis_tdata = w_fifo_out[DATA_WIDTH-1:0];
  assign m_axis_tuser = w_fifo_out[DATA_WIDTH];
  assign busy         = (r_state == ACTIVE);
  assign frame_error  = r_frame_err;

endmodule
`default_nettype wire
